// File: rtl/sdram_wr_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sdram_wr_fifo_ctrl
// Write-side feeder for a full-page SDRAM burst writer. It buffers a 16-bit
// user write stream in a synchronous FIFO. Once cfg_burst_len words are
// stored, it raises one burst request, then pops one word per wr_ack cycle.
// After each burst it advances the SDRAM address linearly, wrapping inside
// [cfg_b_addr, cfg_e_addr).
//
// Optional feature macro: SDRAM_WR_OVF_FLAG_EN
//   defined   -> wr_ovf is a sticky flag. It is set by any user_wr_en that
//                arrives while user_full is high, and cleared by rst or
//                cfg_addr_rst.
//   undefined -> wr_ovf is tied low and dropped pushes are silent.
// ---------------------------------------------------------------------------
module sdram_wr_fifo_ctrl #(
    parameter int DEPTH = 1024,
    parameter int LVL_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             user_wr_en,
    input  logic [15:0]      user_wr_data,
    output logic             user_full,
    input  logic [23:0]      cfg_b_addr,
    input  logic [23:0]      cfg_e_addr,
    input  logic [9:0]       cfg_burst_len,
    input  logic             cfg_addr_rst,
    output logic             wr_en,
    output logic [23:0]      wr_addr,
    output logic [9:0]       wr_burst_len,
    input  logic             wr_ack,
    output logic [15:0]      wr_data,
    input  logic             wr_end,
    output logic [LVL_W-1:0] fifo_level,
    output logic             wr_ovf
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    // FIFO storage (no reset: contents are only meaningful below fifo_level)
    logic [15:0]      mem_q [DEPTH];

    // Registered state and outputs
    state_t           state_q,        state_d;
    logic [AW-1:0]    wr_ptr_q,       wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,       rd_ptr_d;
    logic [LVL_W-1:0] level_q,        level_d;
    logic             user_full_q,    user_full_d;
    logic             wr_en_q,        wr_en_d;
    logic [23:0]      wr_addr_q,      wr_addr_d;
    logic [9:0]       wr_burst_len_q, wr_burst_len_d;
    logic [15:0]      wr_data_q,      wr_data_d;
    logic             pend_q,         pend_d;

    // Combinational helpers
    logic             len_legal_s;
    logic             thresh_s;
    logic             start_ok_s;
    logic             reload_s;
    logic             flush_s;
    logic             push_s;
    logic             pop_s;
    logic [24:0]      adv_s;
    logic [24:0]      adv_end_s;
    logic [23:0]      next_addr_s;

    // Burst start qualification: legal length, enough data, no reload pending
    always_comb begin
        len_legal_s = (cfg_burst_len >= 10'd2) && (cfg_burst_len <= 10'd512);
        thresh_s    = (level_q >= LVL_W'(cfg_burst_len));
        start_ok_s  = len_legal_s && thresh_s && !pend_q;
    end

    // Next burst address: linear advance, back to base if the next burst would pass the window end
    always_comb begin
        adv_s     = {1'b0, wr_addr_q} + {15'd0, wr_burst_len_q};
        adv_end_s = adv_s + {15'd0, wr_burst_len_q};
        if (adv_end_s > {1'b0, cfg_e_addr}) begin
            next_addr_s = cfg_b_addr;
        end else begin
            next_addr_s = adv_s[23:0];
        end
    end

    // Reload/flush decision: immediate in IDLE, deferred to wr_end once a burst is running
    always_comb begin
        reload_s = 1'b0;
        case (state_q)
            ST_IDLE: reload_s = cfg_addr_rst;
            ST_BUSY: reload_s = wr_end && (pend_q || cfg_addr_rst);
            default: reload_s = 1'b0;
        endcase
        flush_s = reload_s;
    end

    // FIFO handshake: full comes from the registered level, underflowing acks are ignored
    always_comb begin
        push_s = user_wr_en && !user_full_q && !flush_s;
        pop_s  = wr_ack && (level_q != {LVL_W{1'b0}}) && !flush_s;
    end

    // FIFO pointers, level, full flag and registered read data
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        wr_data_d = wr_data_q;
        if (flush_s) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            level_d  = {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d  = rd_ptr_q + AW'(1'b1);
                wr_data_d = mem_q[rd_ptr_q];
            end else begin
                rd_ptr_d  = rd_ptr_q;
                wr_data_d = wr_data_q;
            end
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + LVL_W'(1'b1);
                2'b01:   level_d = level_q - LVL_W'(1'b1);
                default: level_d = level_q;
            endcase
        end
        user_full_d = (level_d == LVL_W'(DEPTH));
    end

    // Control FSM next state: request, data phase, address update at wr_end
    always_comb begin
        state_d        = state_q;
        wr_en_d        = wr_en_q;
        wr_addr_d      = wr_addr_q;
        wr_burst_len_d = wr_burst_len_q;
        pend_d         = pend_q;
        case (state_q)
            ST_IDLE: begin
                pend_d  = 1'b0;
                wr_en_d = 1'b0;
                if (cfg_addr_rst) begin
                    wr_addr_d = cfg_b_addr;
                    state_d   = ST_IDLE;
                end else if (start_ok_s) begin
                    state_d        = ST_REQ;
                    wr_en_d        = 1'b1;
                    wr_burst_len_d = cfg_burst_len;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (cfg_addr_rst) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
                if (wr_ack) begin
                    state_d = ST_BUSY;
                    wr_en_d = 1'b0;
                end else begin
                    state_d = ST_REQ;
                    wr_en_d = 1'b1;
                end
            end
            ST_BUSY: begin
                wr_en_d = 1'b0;
                if (wr_end) begin
                    state_d = ST_IDLE;
                    pend_d  = 1'b0;
                    if (reload_s) begin
                        wr_addr_d = cfg_b_addr;
                    end else begin
                        wr_addr_d = next_addr_s;
                    end
                end else begin
                    state_d = ST_BUSY;
                    if (cfg_addr_rst) begin
                        pend_d = 1'b1;
                    end else begin
                        pend_d = pend_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                wr_en_d = 1'b0;
                pend_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= {AW{1'b0}};
            rd_ptr_q       <= {AW{1'b0}};
            level_q        <= {LVL_W{1'b0}};
            user_full_q    <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= cfg_b_addr;
            wr_burst_len_q <= 10'd0;
            wr_data_q      <= 16'd0;
            pend_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            user_full_q    <= user_full_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_burst_len_q <= wr_burst_len_d;
            wr_data_q      <= wr_data_d;
            pend_q         <= pend_d;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= user_wr_data;
        end
    end

`ifdef SDRAM_WR_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    // Sticky overflow: set on a push attempt while full, cleared by an address reload request
    always_comb begin
        if (cfg_addr_rst) begin
            ovf_d = 1'b0;
        end else if (user_wr_en && user_full_q) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign wr_ovf = ovf_q;
`else
    assign wr_ovf = 1'b0;
`endif

    assign user_full    = user_full_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_burst_len = wr_burst_len_q;
    assign wr_data      = wr_data_q;
    assign fifo_level   = level_q;

endmodule

// File: tb/tb_sdram_wr_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for sdram_wr_fifo_ctrl.
// A word scoreboard is filled as words are pushed. Each time the bench acks a
// non-empty FIFO, the oldest entry is popped and compared with wr_data one
// cycle later.
// ---------------------------------------------------------------------------
module tb_sdram_wr_fifo_ctrl;

    localparam int DEPTH = 1024;
    localparam int LVL_W = 11;

    logic             clk;
    logic             rst;
    logic             user_wr_en;
    logic [15:0]      user_wr_data;
    logic             user_full;
    logic [23:0]      cfg_b_addr;
    logic [23:0]      cfg_e_addr;
    logic [9:0]       cfg_burst_len;
    logic             cfg_addr_rst;
    logic             wr_en;
    logic [23:0]      wr_addr;
    logic [9:0]       wr_burst_len;
    logic             wr_ack;
    logic [15:0]      wr_data;
    logic             wr_end;
    logic [LVL_W-1:0] fifo_level;
    logic             wr_ovf;

    int          checks;
    int          errors;
    int          mdl_level;
    logic [15:0] sb[$];
    logic        exp_ovf;

    sdram_wr_fifo_ctrl #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .user_wr_en   (user_wr_en),
        .user_wr_data (user_wr_data),
        .user_full    (user_full),
        .cfg_b_addr   (cfg_b_addr),
        .cfg_e_addr   (cfg_e_addr),
        .cfg_burst_len(cfg_burst_len),
        .cfg_addr_rst (cfg_addr_rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_burst_len (wr_burst_len),
        .wr_ack       (wr_ack),
        .wr_data      (wr_data),
        .wr_end       (wr_end),
        .fifo_level   (fifo_level),
        .wr_ovf       (wr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with the given push/ack inputs; scoreboard and level model follow
    task automatic step(input logic push, input logic [15:0] d, input logic ack);
        logic        pop;
        logic [15:0] exp_w;
        exp_w        = 16'd0;
        user_wr_en   = push;
        user_wr_data = d;
        wr_ack       = ack;
        pop          = ack && (mdl_level > 0);
        if (push && (mdl_level < DEPTH)) begin
            sb.push_back(d);
            mdl_level++;
        end
        if (pop) begin
            exp_w = sb.pop_front();
            mdl_level--;
        end
        tick();
        if (pop) check("wr_data", {16'd0, wr_data}, {16'd0, exp_w});
    endtask

    task automatic push_words(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) step(1'b1, base + 16'(i), 1'b0);
    endtask

    task automatic wait_wr_en();
        int cyc;
        cyc = 0;
        while (wr_en !== 1'b1 && cyc < 64) begin
            step(1'b0, 16'd0, 1'b0);
            cyc++;
        end
        check("wr_en_rise", {31'd0, wr_en}, 32'd1);
    endtask

    // Writer model: ack n cycles (optionally pushing alongside), then pulse wr_end
    task automatic run_burst(input int n, input logic push, input logic [15:0] base, input int rst_idx);
        wait_wr_en();
        for (int i = 0; i < n; i++) begin
            cfg_addr_rst = (i == rst_idx);
            step(push, base + 16'(i), 1'b1);
            if (i == 0) check("wr_en_drop", {31'd0, wr_en}, 32'd0);
        end
        cfg_addr_rst = 1'b0;
        wr_end = 1'b1;
        step(1'b0, 16'd0, 1'b0);
        wr_end = 1'b0;
        check("wr_en_after_end", {31'd0, wr_en}, 32'd0);
    endtask

    task automatic pulse_addr_rst();
        cfg_addr_rst = 1'b1;
        step(1'b0, 16'd0, 1'b0);
        cfg_addr_rst = 1'b0;
        sb.delete();
        mdl_level = 0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        mdl_level     = 0;
`ifdef SDRAM_WR_OVF_FLAG_EN
        exp_ovf       = 1'b1;
`else
        exp_ovf       = 1'b0;
`endif
        rst           = 1'b1;
        user_wr_en    = 1'b0;
        user_wr_data  = 16'd0;
        cfg_b_addr    = 24'h0ABC00;
        cfg_e_addr    = 24'h000400;
        cfg_burst_len = 10'd8;
        cfg_addr_rst  = 1'b0;
        wr_ack        = 1'b0;
        wr_end        = 1'b0;

        // Reset values
        step(1'b0, 16'd0, 1'b0);
        step(1'b0, 16'd0, 1'b0);
        check("rst_wr_en",     {31'd0, wr_en},       32'd0);
        check("rst_wr_addr",   {8'd0, wr_addr},      32'h000ABC00);
        check("rst_burst_len", {22'd0, wr_burst_len},32'd0);
        check("rst_wr_data",   {16'd0, wr_data},     32'd0);
        check("rst_level",     {21'd0, fifo_level},  32'd0);
        check("rst_full",      {31'd0, user_full},   32'd0);
        check("rst_ovf",       {31'd0, wr_ovf},      32'd0);
        rst = 1'b0;

        // Reload in IDLE
        cfg_b_addr = 24'h000000;
        pulse_addr_rst();
        check("idle_reload_addr", {8'd0, wr_addr}, 32'h0);

        // Threshold: 8 words, request one cycle after level reaches 8
        push_words(8, 16'h0001);
        check("thr_level", {21'd0, fifo_level}, 32'd8);
        check("thr_wr_en_low", {31'd0, wr_en}, 32'd0);
        step(1'b0, 16'd0, 1'b0);
        check("thr_wr_en_high", {31'd0, wr_en}, 32'd1);
        check("thr_burst_len", {22'd0, wr_burst_len}, 32'd8);
        check("thr_addr", {8'd0, wr_addr}, 32'h0);
        run_burst(8, 1'b0, 16'd0, -1);
        check("thr_next_addr", {8'd0, wr_addr}, 32'h000008);
        check("thr_level_end", {21'd0, fifo_level}, 32'd0);

        // Wrap inside window 0x000000..0x000020 with length 16
        cfg_e_addr    = 24'h000020;
        cfg_burst_len = 10'd16;
        pulse_addr_rst();
        check("wrap_addr0", {8'd0, wr_addr}, 32'h0);
        push_words(16, 16'h0100);
        run_burst(16, 1'b0, 16'd0, -1);
        check("wrap_addr1", {8'd0, wr_addr}, 32'h000010);
        push_words(16, 16'h0200);
        run_burst(16, 1'b0, 16'd0, -1);
        check("wrap_addr2", {8'd0, wr_addr}, 32'h0);

        // Simultaneous push and pop during a 16-word burst
        cfg_e_addr = 24'h000400;
        push_words(16, 16'h0300);
        run_burst(16, 1'b1, 16'h0400, -1);
        check("sim_level", {21'd0, fifo_level}, 32'd16);
        check("sim_addr1", {8'd0, wr_addr}, 32'h000010);
        step(1'b0, 16'd0, 1'b0);
        check("sim_gap_req", {31'd0, wr_en}, 32'd1);
        run_burst(16, 1'b0, 16'd0, -1);
        check("sim_addr2", {8'd0, wr_addr}, 32'h000020);
        check("sim_level_end", {21'd0, fifo_level}, 32'd0);

        // Full / overflow with an illegal length so no burst starts
        cfg_burst_len = 10'd0;
        pulse_addr_rst();
        push_words(DEPTH, 16'h1000);
        check("full_flag", {31'd0, user_full}, 32'd1);
        check("full_level", {21'd0, fifo_level}, 32'd1024);
        check("full_ovf_before", {31'd0, wr_ovf}, 32'd0);
        step(1'b1, 16'hFFFF, 1'b0);
        check("full_drop_level", {21'd0, fifo_level}, 32'd1024);
        check("full_ovf", {31'd0, wr_ovf}, {31'd0, exp_ovf});
        check("full_no_req", {31'd0, wr_en}, 32'd0);
        pulse_addr_rst();
        check("flush_level", {21'd0, fifo_level}, 32'd0);
        check("flush_full", {31'd0, user_full}, 32'd0);
        check("flush_ovf", {31'd0, wr_ovf}, 32'd0);

        // Pending reload during BUSY
        cfg_b_addr = 24'h000100;
        pulse_addr_rst();
        check("pend_start_addr", {8'd0, wr_addr}, 32'h000100);
        cfg_b_addr    = 24'h000200;
        cfg_burst_len = 10'd8;
        push_words(12, 16'h2000);
        run_burst(8, 1'b0, 16'd0, 1);
        sb.delete();
        mdl_level = 0;
        check("pend_addr", {8'd0, wr_addr}, 32'h000200);
        check("pend_level", {21'd0, fifo_level}, 32'd0);
        step(1'b0, 16'd0, 1'b0);
        check("pend_no_req", {31'd0, wr_en}, 32'd0);

        // Illegal length 1 keeps IDLE; then reset mid-REQ
        cfg_burst_len = 10'd1;
        push_words(10, 16'h3000);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'd0, 1'b0);
            check("len1_no_req", {31'd0, wr_en}, 32'd0);
        end
        cfg_burst_len = 10'd8;
        step(1'b0, 16'd0, 1'b0);
        check("len8_req", {31'd0, wr_en}, 32'd1);
        rst = 1'b1;
        step(1'b0, 16'd0, 1'b0);
        rst = 1'b0;
        sb.delete();
        mdl_level = 0;
        check("midrst_wr_en", {31'd0, wr_en}, 32'd0);
        check("midrst_level", {21'd0, fifo_level}, 32'd0);
        check("midrst_burst_len", {22'd0, wr_burst_len}, 32'd0);
        check("midrst_addr", {8'd0, wr_addr}, 32'h000200);

        // Underflow: third ack on an empty FIFO leaves wr_data and level alone
        cfg_burst_len = 10'd0;
        step(1'b1, 16'hAAAA, 1'b0);
        step(1'b1, 16'hBBBB, 1'b0);
        step(1'b0, 16'd0, 1'b1);
        step(1'b0, 16'd0, 1'b1);
        step(1'b0, 16'd0, 1'b1);
        check("udf_data_hold", {16'd0, wr_data}, 32'h0000BBBB);
        check("udf_level", {21'd0, fifo_level}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
